// File: rtl/aurora_mmcm_pkg.sv
// ============================================================================
// Module   : aurora_mmcm_pkg
// Brief    : Shared state encoding and constants for the Aurora MMCM supervisor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aurora_mmcm_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        ST_WAIT_PLL  = 3'd0,
        ST_MMCM_RST  = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_RUN       = 3'd4
    } chan_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aurora_mmcm_chan_fsm.sv
// ============================================================================
// Module   : aurora_mmcm_chan_fsm
// Brief    : One MMCM channel: lock synchronizers, bring-up FSM, sticky timeout
//            flag and (with AURORA_MMCM_UNLOCK_CNT_EN) a saturating unlock counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aurora_mmcm_chan_fsm
    import aurora_mmcm_pkg::*;
#(
    parameter int RST_CYCLES    = 64,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pll_locked,
    input  logic                 mmcm_locked,
    input  logic                 force_reset,
    input  logic                 clear,
    output logic                 mmcm_reset,
    output logic                 chan_reset,
    output logic                 chan_ready,
    output logic                 timeout_flag,
    output logic [CNT_WIDTH-1:0] unlock_count
);

    localparam int TW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES) + 1);
    localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] pll_sync;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   pll_s;
    logic                   lock_s;
    chan_state_t            state;
    chan_state_t            state_nxt;
    logic [TW-1:0]          tmr;
    logic [TW-1:0]          tmr_nxt;
    logic                   timeout_evt;

    assign pll_s  = pll_sync[SYNC_STAGES-1];
    assign lock_s = lock_sync[SYNC_STAGES-1];

    // Timer restarts at zero on every state entry; it only advances while holding.
    always_comb begin
        state_nxt   = state;
        tmr_nxt     = '0;
        timeout_evt = 1'b0;
        if (!pll_s) begin
            state_nxt = ST_WAIT_PLL;
        end else if (force_reset && (state != ST_WAIT_PLL)) begin
            state_nxt = ST_MMCM_RST;
        end else begin
            case (state)
                ST_WAIT_PLL: state_nxt = ST_MMCM_RST;
                ST_MMCM_RST: begin
                    if (tmr == RST_LAST) state_nxt = ST_WAIT_LOCK;
                    else                 tmr_nxt   = tmr + 1'b1;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = ST_SETTLE;
                    end else if (tmr == LOCK_LAST) begin
                        timeout_evt = 1'b1;
                        state_nxt   = ST_MMCM_RST;
                    end else begin
                        tmr_nxt = tmr + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!lock_s)                 state_nxt = ST_WAIT_LOCK;
                    else if (tmr == SETTLE_LAST) state_nxt = ST_RUN;
                    else                         tmr_nxt   = tmr + 1'b1;
                end
                ST_RUN: begin
                    if (!lock_s) state_nxt = ST_MMCM_RST;
                end
                default: state_nxt = ST_WAIT_PLL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_sync     <= '0;
            lock_sync    <= '0;
            state        <= ST_WAIT_PLL;
            tmr          <= '0;
            mmcm_reset   <= 1'b1;
            chan_reset   <= 1'b1;
            chan_ready   <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            pll_sync     <= {pll_sync[SYNC_STAGES-2:0], pll_locked};
            lock_sync    <= {lock_sync[SYNC_STAGES-2:0], mmcm_locked};
            state        <= state_nxt;
            tmr          <= tmr_nxt;
            mmcm_reset   <= (state == ST_WAIT_PLL) || (state == ST_MMCM_RST);
            chan_ready   <= (state == ST_RUN);
            chan_reset   <= (state != ST_RUN);
            // A timeout on the same cycle as CLEAR must remain visible.
            timeout_flag <= timeout_evt | (timeout_flag & ~clear);
        end
    end

`ifdef AURORA_MMCM_UNLOCK_CNT_EN
    logic                 unlock_evt;
    logic [CNT_WIDTH-1:0] unlock_cnt;

    assign unlock_evt = (state == ST_RUN) && pll_s && !force_reset && !lock_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unlock_cnt <= '0;
        end else if (clear) begin
            unlock_cnt <= '0;
        end else if (unlock_evt && (unlock_cnt != {CNT_WIDTH{1'b1}})) begin
            unlock_cnt <= unlock_cnt + 1'b1;
        end
    end

    assign unlock_count = unlock_cnt;
`else
    assign unlock_count = '0;
`endif

endmodule

`default_nettype wire

// File: rtl/aurora_mmcm_supervisor.sv
// ============================================================================
// Module   : aurora_mmcm_supervisor
// Brief    : Supervises NCHAN Aurora MMCMs; reset release synchronizer plus one
//            channel FSM per MMCM. Unlock counters need AURORA_MMCM_UNLOCK_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aurora_mmcm_supervisor
    import aurora_mmcm_pkg::*;
#(
    parameter int NCHAN         = 4,
    parameter int RST_CYCLES    = 64,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                       INIT_CLK,
    input  logic                       INIT_RST_N,
    input  logic [NCHAN-1:0]           TX_PLL_LOCKED,
    input  logic [NCHAN-1:0]           MMCM_LOCKED,
    input  logic [NCHAN-1:0]           FORCE_RESET,
    input  logic                       CLEAR,
    output logic [NCHAN-1:0]           MMCM_RESET,
    output logic [NCHAN-1:0]           CHAN_RESET,
    output logic [NCHAN-1:0]           CHAN_READY,
    output logic [NCHAN-1:0]           TIMEOUT_FLAG,
    output logic [NCHAN*CNT_WIDTH-1:0] UNLOCK_COUNT
);

    logic [SYNC_STAGES-1:0] rst_sync;
    logic                   core_rst_n;

    // Assertion propagates immediately; release is retimed onto INIT_CLK.
    always_ff @(posedge INIT_CLK or negedge INIT_RST_N) begin
        if (!INIT_RST_N) rst_sync <= '0;
        else             rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
    end

    assign core_rst_n = rst_sync[SYNC_STAGES-1];

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        aurora_mmcm_chan_fsm #(
            .RST_CYCLES    (RST_CYCLES),
            .LOCK_TIMEOUT  (LOCK_TIMEOUT),
            .SETTLE_CYCLES (SETTLE_CYCLES),
            .CNT_WIDTH     (CNT_WIDTH)
        ) u_chan (
            .clk          (INIT_CLK),
            .rst_n        (core_rst_n),
            .pll_locked   (TX_PLL_LOCKED[i]),
            .mmcm_locked  (MMCM_LOCKED[i]),
            .force_reset  (FORCE_RESET[i]),
            .clear        (CLEAR),
            .mmcm_reset   (MMCM_RESET[i]),
            .chan_reset   (CHAN_RESET[i]),
            .chan_ready   (CHAN_READY[i]),
            .timeout_flag (TIMEOUT_FLAG[i]),
            .unlock_count (UNLOCK_COUNT[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_aurora_mmcm_supervisor.sv
// ============================================================================
// Module   : tb_aurora_mmcm_supervisor
// Brief    : Self-checking bench for aurora_mmcm_supervisor (2 channels).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aurora_mmcm_supervisor;

    localparam int NCH  = 2;
    localparam int RSTC = 8;
    localparam int LTO  = 100;
    localparam int SETC = 4;
    localparam int CW   = 2;
`ifdef AURORA_MMCM_UNLOCK_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NCH-1:0]      pll;
    logic [NCH-1:0]      lock;
    logic [NCH-1:0]      force_rst;
    logic                clear;
    logic [NCH-1:0]      mmcm_reset;
    logic [NCH-1:0]      chan_reset;
    logic [NCH-1:0]      chan_ready;
    logic [NCH-1:0]      timeout_flag;
    logic [NCH*CW-1:0]   unlock_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aurora_mmcm_supervisor #(
        .NCHAN         (NCH),
        .RST_CYCLES    (RSTC),
        .LOCK_TIMEOUT  (LTO),
        .SETTLE_CYCLES (SETC),
        .CNT_WIDTH     (CW)
    ) dut (
        .INIT_CLK      (clk),
        .INIT_RST_N    (rst_n),
        .TX_PLL_LOCKED (pll),
        .MMCM_LOCKED   (lock),
        .FORCE_RESET   (force_rst),
        .CLEAR         (clear),
        .MMCM_RESET    (mmcm_reset),
        .CHAN_RESET    (chan_reset),
        .CHAN_READY    (chan_ready),
        .TIMEOUT_FLAG  (timeout_flag),
        .UNLOCK_COUNT  (unlock_count)
    );

    // Reference model: phases 0=no PLL, 1=reset pulse, 2=awaiting lock,
    // 3=settling, 4=running; 'left' counts remaining cycles of the phase.
    int          ph   [NCH];
    int          left [NCH];
    logic [1:0]  pll_h  [NCH];
    logic [1:0]  lock_h [NCH];
    logic        m_mr  [NCH];
    logic        m_rdy [NCH];
    logic        m_to  [NCH];
    logic [CW-1:0] m_cnt [NCH];
    int          rel;

    always @(posedge clk or negedge rst_n) begin : model
        int  old;
        bit  ps, ls, tmo, lost;
        if (!rst_n) begin
            rel = 0;
            for (int c = 0; c < NCH; c++) begin
                ph[c] = 0; left[c] = 0; pll_h[c] = 2'b00; lock_h[c] = 2'b00;
                m_mr[c] = 1'b1; m_rdy[c] = 1'b0; m_to[c] = 1'b0; m_cnt[c] = '0;
            end
        end else if (rel < 2) begin
            rel = rel + 1;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                old = ph[c]; ps = pll_h[c][1]; ls = lock_h[c][1]; tmo = 0; lost = 0;
                if (!ps) ph[c] = 0;
                else if (force_rst[c] && old != 0) begin ph[c] = 1; left[c] = RSTC; end
                else if (old == 0) begin ph[c] = 1; left[c] = RSTC; end
                else if (old == 1) begin
                    left[c] = left[c] - 1;
                    if (left[c] == 0) begin ph[c] = 2; left[c] = LTO; end
                end else if (old == 2) begin
                    if (ls) begin ph[c] = 3; left[c] = SETC; end
                    else begin
                        left[c] = left[c] - 1;
                        if (left[c] == 0) begin tmo = 1; ph[c] = 1; left[c] = RSTC; end
                    end
                end else if (old == 3) begin
                    if (!ls) begin ph[c] = 2; left[c] = LTO; end
                    else begin
                        left[c] = left[c] - 1;
                        if (left[c] == 0) ph[c] = 4;
                    end
                end else if (!ls) begin
                    lost = 1; ph[c] = 1; left[c] = RSTC;
                end
                m_mr[c]  = (old <= 1);
                m_rdy[c] = (old == 4);
                m_to[c]  = tmo ? 1'b1 : (clear ? 1'b0 : m_to[c]);
                if (CNT_EN) begin
                    if (clear) m_cnt[c] = '0;
                    else if (lost && m_cnt[c] != {CW{1'b1}}) m_cnt[c] = m_cnt[c] + 1'b1;
                end
                pll_h[c]  = {pll_h[c][0], pll[c]};
                lock_h[c] = {lock_h[c][0], lock[c]};
            end
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (mmcm_reset !== 2'b11) begin errors++; $display("FAIL reset_mmcm_reset got %b want 11", mmcm_reset); end
        checks++; if (chan_reset !== 2'b11) begin errors++; $display("FAIL reset_chan_reset got %b want 11", chan_reset); end
        checks++; if (chan_ready !== 2'b00) begin errors++; $display("FAIL reset_chan_ready got %b want 00", chan_ready); end
        checks++; if (timeout_flag !== 2'b00) begin errors++; $display("FAIL reset_timeout got %b want 00", timeout_flag); end
        checks++; if (unlock_count !== '0) begin errors++; $display("FAIL reset_unlock got %h want 0", unlock_count); end
    endtask

    task automatic test_bringup();
        int lat0, lat1;
        rst_n = 1'b1;
        pll   = 2'b11;
        repeat (20) @(negedge clk);
        checks++; if (mmcm_reset !== 2'b00) begin errors++; $display("FAIL bringup_wait_lock got %b want 00", mmcm_reset); end
        lock = 2'b11;
        lat0 = 0; lat1 = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (chan_ready[0] && lat0 == 0) lat0 = k;
            if (chan_ready[1] && lat1 == 0) lat1 = k;
        end
        @(negedge clk);
        checks++; if (lat0 != 8) begin errors++; $display("FAIL bringup_ready_latency ch0 got %0d want 8", lat0); end
        checks++; if (lat1 != 8) begin errors++; $display("FAIL bringup_ready_latency ch1 got %0d want 8", lat1); end
        checks++; if (chan_reset !== 2'b00) begin errors++; $display("FAIL bringup_chan_reset got %b want 00", chan_reset); end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if ({mmcm_reset[c], chan_reset[c], chan_ready[c], timeout_flag[c], unlock_count[c*CW +: CW]} !==
                {m_mr[c], ~m_rdy[c], m_rdy[c], m_to[c], m_cnt[c]}) begin
                errors++; $display("FAIL bringup_model ch%0d got %b%b%b%b%b want %b%b%b%b%b", c,
                    mmcm_reset[c], chan_reset[c], chan_ready[c], timeout_flag[c], unlock_count[c*CW +: CW],
                    m_mr[c], ~m_rdy[c], m_rdy[c], m_to[c], m_cnt[c]);
            end
        end
    endtask

    task automatic test_glitch();
        int lat;
        lock[0] = 1'b0;
        repeat (15) @(negedge clk);
        lock[0] = 1'b1;
        repeat (3) @(negedge clk);
        lock[0] = 1'b0;
        checks++; if (chan_ready[0] !== 1'b0) begin errors++; $display("FAIL glitch_not_ready got %b want 0", chan_ready[0]); end
        @(negedge clk);
        lock[0] = 1'b1;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (chan_ready[0] && lat == 0) lat = k;
        end
        @(negedge clk);
        checks++; if (lat != 8) begin errors++; $display("FAIL glitch_ready_latency got %0d want 8", lat); end
        checks++; if (chan_ready[1] !== 1'b1) begin errors++; $display("FAIL glitch_other_chan got %b want 1", chan_ready[1]); end
    endtask

    task automatic test_loss_in_run();
        int n;
        lock[1] = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (chan_reset[1] !== 1'b1) begin errors++; $display("FAIL loss_chan_reset got %b want 1", chan_reset[1]); end
        checks++; if (unlock_count[3:2] !== (CNT_EN ? 2'd1 : 2'd0)) begin errors++; $display("FAIL loss_count1 got %0d want %0d", unlock_count[3:2], CNT_EN ? 1 : 0); end
        checks++; if (chan_ready[0] !== 1'b1) begin errors++; $display("FAIL loss_ch0_unaffected got %b want 1", chan_ready[0]); end
        for (int r = 0; r < 5; r++) begin
            if (r > 0) begin
                lock[1] = 1'b0;
                repeat (4) @(negedge clk);
            end
            lock[1] = 1'b1;
            n = 0;
            while (chan_ready[1] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
            checks++; if (chan_ready[1] !== 1'b1) begin errors++; $display("FAIL loss_recover round %0d got %b want 1", r, chan_ready[1]); end
        end
        checks++; if (unlock_count[3:2] !== (CNT_EN ? 2'd3 : 2'd0)) begin errors++; $display("FAIL loss_saturate got %0d want %0d", unlock_count[3:2], CNT_EN ? 3 : 0); end
        // CLEAR lands on the same edge as the increment.
        lock[1] = 1'b0;
        @(negedge clk); @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++; if (unlock_count[3:2] !== 2'd0) begin errors++; $display("FAIL loss_clear_wins got %0d want 0", unlock_count[3:2]); end
        lock[1] = 1'b1;
        n = 0;
        while (chan_ready[1] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if ({mmcm_reset[c], chan_reset[c], chan_ready[c], timeout_flag[c], unlock_count[c*CW +: CW]} !==
                {m_mr[c], ~m_rdy[c], m_rdy[c], m_to[c], m_cnt[c]}) begin
                errors++; $display("FAIL loss_model ch%0d got %b%b%b%b%b want %b%b%b%b%b", c,
                    mmcm_reset[c], chan_reset[c], chan_ready[c], timeout_flag[c], unlock_count[c*CW +: CW],
                    m_mr[c], ~m_rdy[c], m_rdy[c], m_to[c], m_cnt[c]);
            end
        end
    endtask

    task automatic test_timeout();
        int n, hi, lo;
        lock[0] = 1'b0;
        n = 0;
        while (mmcm_reset[0] !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        hi = 0;
        while (mmcm_reset[0] === 1'b1 && hi < 50) begin hi++; @(negedge clk); end
        checks++; if (hi != RSTC) begin errors++; $display("FAIL timeout_first_pulse got %0d want %0d", hi, RSTC); end
        lo = 0;
        while (mmcm_reset[0] === 1'b0 && lo < 300) begin lo++; @(negedge clk); end
        checks++; if (lo != LTO) begin errors++; $display("FAIL timeout_wait_len got %0d want %0d", lo, LTO); end
        checks++; if (timeout_flag[0] !== 1'b1) begin errors++; $display("FAIL timeout_flag_set got %b want 1", timeout_flag[0]); end
        hi = 0;
        while (mmcm_reset[0] === 1'b1 && hi < 50) begin hi++; @(negedge clk); end
        checks++; if (hi != RSTC) begin errors++; $display("FAIL timeout_repulse got %0d want %0d", hi, RSTC); end
        // Second timeout with CLEAR on the very same edge.
        lo = 0;
        while (mmcm_reset[0] === 1'b0 && lo < 300) begin lo++; clear = (lo == LTO - 1); @(negedge clk); end
        clear = 1'b0;
        checks++; if (lo != LTO) begin errors++; $display("FAIL timeout_wait_len2 got %0d want %0d", lo, LTO); end
        checks++; if (timeout_flag[0] !== 1'b1) begin errors++; $display("FAIL timeout_clear_coincide got %b want 1", timeout_flag[0]); end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++; if (timeout_flag[0] !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b want 0", timeout_flag[0]); end
    endtask

    task automatic test_priority();
        int n;
        lock[0] = 1'b1;
        n = 0;
        while (chan_ready[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++; if (chan_ready[0] !== 1'b1) begin errors++; $display("FAIL priority_setup got %b want 1", chan_ready[0]); end
        pll[0] = 1'b0;
        @(negedge clk); @(negedge clk);
        force_rst[0] = 1'b1;
        @(negedge clk);
        force_rst[0] = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (mmcm_reset[0] !== 1'b1) begin errors++; $display("FAIL priority_wait_pll got %b want 1", mmcm_reset[0]); end
        checks++; if (chan_ready !== 2'b10) begin errors++; $display("FAIL priority_ready got %b want 10", chan_ready); end
        pll[0] = 1'b1;
        n = 0;
        while (chan_ready[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++; if (chan_ready[0] !== 1'b1) begin errors++; $display("FAIL priority_recover got %b want 1", chan_ready[0]); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mmcm_reset !== 2'b11) begin errors++; $display("FAIL midrst_mmcm_reset got %b want 11", mmcm_reset); end
        checks++; if (chan_reset !== 2'b11) begin errors++; $display("FAIL midrst_chan_reset got %b want 11", chan_reset); end
        checks++; if (chan_ready !== 2'b00) begin errors++; $display("FAIL midrst_chan_ready got %b want 00", chan_ready); end
        checks++; if (timeout_flag !== 2'b00) begin errors++; $display("FAIL midrst_timeout got %b want 00", timeout_flag); end
        checks++; if (unlock_count !== '0) begin errors++; $display("FAIL midrst_unlock got %h want 0", unlock_count); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (chan_ready !== 2'b11) begin errors++; $display("FAIL midrst_recover got %b want 11", chan_ready); end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if ({mmcm_reset[c], chan_reset[c], chan_ready[c], timeout_flag[c], unlock_count[c*CW +: CW]} !==
                    {m_mr[c], ~m_rdy[c], m_rdy[c], m_to[c], m_cnt[c]}) begin
                    errors++; $display("FAIL random_model cyc%0d ch%0d got %b%b%b%b%b want %b%b%b%b%b", cyc, c,
                        mmcm_reset[c], chan_reset[c], chan_ready[c], timeout_flag[c], unlock_count[c*CW +: CW],
                        m_mr[c], ~m_rdy[c], m_rdy[c], m_to[c], m_cnt[c]);
                end
            end
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 249) == 0) pll[c] = ~pll[c];
                if ($urandom_range(0, (cyc < 1500) ? 25 : 160) == 0) lock[c] = ~lock[c];
                force_rst[c] = ($urandom_range(0, 149) == 0);
            end
            clear = ($urandom_range(0, 99) == 0);
        end
        force_rst = '0;
        clear     = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        pll       = '0;
        lock      = '0;
        force_rst = '0;
        clear     = 1'b0;
        test_reset();
        test_bringup();
        test_glitch();
        test_loss_in_run();
        test_timeout();
        test_priority();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/aurora_mmcm_supervisor.md
AURORA_MMCM_SUPERVISOR -- requirements
Module: aurora_mmcm_supervisor

Interface
REQ-001 The block SHALL have parameter NCHAN, default 4, giving the number of independent MMCM channels supervised (1..8).
REQ-002 The block SHALL have parameter RST_CYCLES, default 64, giving the MMCM reset hold time in INIT_CLK cycles (>=2).
REQ-003 The block SHALL have parameter LOCK_TIMEOUT, default 65536, giving the maximum number of cycles spent waiting for lock.
REQ-004 The block SHALL have parameter SETTLE_CYCLES, default 16, giving the number of consecutive locked cycles required before ready.
REQ-005 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of each unlock-event counter.
REQ-006 The block SHALL have port INIT_CLK, input, width 1: the single clock; all logic is on it.
REQ-007 The block SHALL have port INIT_RST_N, input, width 1: asynchronous, active-low reset.
REQ-008 The block SHALL have port TX_PLL_LOCKED, input, width NCHAN: asynchronous, GT PLL lock per channel.
REQ-009 The block SHALL have port MMCM_LOCKED, input, width NCHAN: asynchronous, MMCM LOCKED per channel.
REQ-010 The block SHALL have port FORCE_RESET, input, width NCHAN: synchronous, a one-cycle pulse requests an MMCM reset.
REQ-011 The block SHALL have port CLEAR, input, width 1: synchronous, clears all TIMEOUT_FLAG bits and unlock counters.
REQ-012 The block SHALL have port MMCM_RESET, output, width NCHAN: drives the MMCM RST pin.
REQ-013 The block SHALL have port CHAN_RESET, output, width NCHAN: active-high reset to the downstream Aurora core.
REQ-014 The block SHALL have port CHAN_READY, output, width NCHAN: the channel clocks are stable.
REQ-015 The block SHALL have port TIMEOUT_FLAG, output, width NCHAN: sticky, set when a lock timeout occurs.
REQ-016 The block SHALL have port UNLOCK_COUNT, output, width NCHAN*CNT_WIDTH: per-channel loss-of-lock count, channel i at bits [i*CNT_WIDTH +: CNT_WIDTH].

Function
REQ-017 Each TX_PLL_LOCKED and MMCM_LOCKED bit SHALL pass through a 2-flop synchronizer; all decisions use the synchronized values (2-cycle input latency).
REQ-018 Each channel SHALL run an independent FSM with states WAIT_PLL, MMCM_RST, WAIT_LOCK, SETTLE, RUN.
REQ-019 In WAIT_PLL, the FSM SHALL move to MMCM_RST when synced TX_PLL_LOCKED=1.
REQ-020 In MMCM_RST, the FSM SHALL hold for exactly RST_CYCLES cycles, then move to WAIT_LOCK.
REQ-021 In WAIT_LOCK, the FSM SHALL move to SETTLE when synced MMCM_LOCKED=1; after LOCK_TIMEOUT cycles without lock it SHALL set TIMEOUT_FLAG[i] and return to MMCM_RST.
REQ-022 In SETTLE, the FSM SHALL move to RUN after SETTLE_CYCLES consecutive locked cycles; any unlocked cycle SHALL return it to WAIT_LOCK with the timeout counter restarted.
REQ-023 In RUN, synced MMCM_LOCKED=0 SHALL cause a move to MMCM_RST and increment UNLOCK_COUNT[i].
REQ-024 Priority, highest first: synced TX_PLL_LOCKED=0 (any state to WAIT_PLL), then FORCE_RESET[i] (any state except WAIT_PLL to MMCM_RST, counter reloaded), then the normal transitions.
REQ-025 MMCM_RESET[i] SHALL be 1 in WAIT_PLL and MMCM_RST and 0 otherwise.
REQ-026 CHAN_READY[i] SHALL be 1 only in RUN, and CHAN_RESET[i] SHALL be its complement.
REQ-027 All outputs SHALL be registered and SHALL change on the cycle following the state change.
REQ-028 UNLOCK_COUNT SHALL saturate at 2^CNT_WIDTH-1 with no wrap.
REQ-029 When CLEAR and an increment coincide, CLEAR SHALL win and the result SHALL be 0.
REQ-030 When CLEAR and a timeout coincide, the flag SHALL read 1.
REQ-031 Each channel's counters SHALL be sized with $clog2 of max(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES)+1.

Reset
REQ-032 While INIT_RST_N=0, all FSMs SHALL be in WAIT_PLL, with MMCM_RESET all 1, CHAN_RESET all 1, CHAN_READY 0, TIMEOUT_FLAG 0, UNLOCK_COUNT 0 and the synchronizers at 0.
REQ-033 Assertion of INIT_RST_N mid-operation SHALL immediately force these values; deassertion SHALL be synchronized internally via a 2-flop release.

Configuration
REQ-034 With the macro AURORA_MMCM_UNLOCK_CNT_EN defined, the block SHALL implement the UNLOCK_COUNT counters.
REQ-035 Without AURORA_MMCM_UNLOCK_CNT_EN, UNLOCK_COUNT SHALL be tied to 0 with no counter registers, CLEAR SHALL affect only TIMEOUT_FLAG, and all other behaviour SHALL be unchanged.

Structure
REQ-036 The FSM state encoding and the synchronizer depth constant SHALL reside in the shared package aurora_mmcm_pkg.
REQ-037 Per-channel logic SHALL be a sub-module, aurora_mmcm_chan_fsm, instantiated NCHAN times in a generate loop; the top level holds only the reset synchronizer and output packing.

Verification (NCHAN=2, RST_CYCLES=8, LOCK_TIMEOUT=100, SETTLE_CYCLES=4)
REQ-038 Bring-up: raise PLL, then MMCM_LOCKED 20 cycles later -> MMCM_RESET high 8 cycles; CHAN_READY rises 4+sync cycles after lock.
REQ-039 Timeout: MMCM_LOCKED held low -> TIMEOUT_FLAG[0]=1 after 100 WAIT_LOCK cycles and MMCM_RESET re-pulses for 8 cycles; CLEAR then yields flag 0.
REQ-040 Glitch: in SETTLE, drop lock for 1 cycle -> no RUN entry; CHAN_READY rises only after 4 fresh locked cycles.
REQ-041 Loss in RUN: drop channel 1 lock -> UNLOCK_COUNT[1]=1, CHAN_RESET[1]=1, and channel 0 is unaffected; with CNT_WIDTH=2 and 5 losses the count is 3.
REQ-042 Priority: FORCE_RESET and PLL loss in the same cycle -> WAIT_PLL.
REQ-043 Mid-operation reset: INIT_RST_N pulsed in RUN -> all outputs reach their reset values asynchronously.
